// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: issues one word fetch at a time, holds the returned
// instruction until the decoder consumes it, then advances the pc sequentially
// or by a jal offset. Stops permanently on ebreak or a misaligned target.
module ysyx_22040237_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [31:0] inst,
  input  logic        jump_flag,
  input  logic [31:0] src_j,
  input  logic        inst_ebreak,
  output logic        halted,
  output logic        misalign_err,
  output logic [63:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic [63:0] retire_cnt_reg;
  logic        req_valid_reg;
  logic        inst_valid_reg;
  logic        halted_reg;
  logic        misalign_err_reg;

  logic        consume;
  logic [31:0] pc_next;

  // Decoder handshake and candidate next pc (wraps modulo 2^32 naturally)
  always_comb begin
    consume = inst_valid_reg & inst_ready;
    pc_next = pc_reg + (jump_flag ? src_j : 32'd4);
  end

  // Fetch FSM with registered handshake outputs. The request valid flag
  // resets low and rises on the first clock after reset release, so no
  // request is ever visible while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= S_REQ;
      pc_reg           <= RESET_PC;
      inst_reg         <= 32'd0;
      retire_cnt_reg   <= 64'd0;
      req_valid_reg    <= 1'b0;
      inst_valid_reg   <= 1'b0;
      halted_reg       <= 1'b0;
      misalign_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (req_valid_reg && imem_req_ready) begin
            req_valid_reg <= 1'b0;
            state_reg     <= S_WAIT;
          end else begin
            req_valid_reg <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst_reg       <= imem_rsp_data;
            inst_valid_reg <= 1'b1;
            state_reg      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (consume) begin
            retire_cnt_reg <= retire_cnt_reg + 64'd1;
            inst_valid_reg <= 1'b0;
            if (inst_ebreak) begin
              halted_reg <= 1'b1;
              state_reg  <= S_HALT;
            end else if (pc_next[1:0] != 2'b00) begin
              halted_reg       <= 1'b1;
              misalign_err_reg <= 1'b1;
              state_reg        <= S_HALT;
            end else begin
              pc_reg        <= pc_next;
              req_valid_reg <= 1'b1;
              state_reg     <= S_REQ;
            end
          end
        end
        default: begin
          // Terminal halt: everything holds until reset
          state_reg <= S_HALT;
        end
      endcase
    end
  end

  // Output mapping
  always_comb begin
    imem_req_valid = req_valid_reg;
    imem_req_addr  = pc_reg;
    inst_valid     = inst_valid_reg;
    pc             = pc_reg;
    inst           = inst_reg;
    halted         = halted_reg;
    misalign_err   = misalign_err_reg;
    retire_cnt     = retire_cnt_reg;
  end

endmodule
